// File: rtl/d_mem_arbiter_if.sv
// Bundle of the two requester ports and the D_MEM-facing bus of d_mem_arbiter.
// Latency: none, wires only.
// Backpressure: none here; requesters hold req until they see their gnt pulse.
// Ports: req/we/addr/wdata/gnt/rvalid per requester, shared rdata, and
//        mem_address/mem_write_data/mem_memwrite/mem_memread/mem_read_data.
// slave  = arbiter side; master = requesters plus the memory they share.
interface d_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              gnt0;
    logic              rvalid0;

    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              gnt1;
    logic              rvalid1;

    logic [DATA_W-1:0] rdata;

    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_memwrite;
    logic              mem_memread;
    logic [DATA_W-1:0] mem_read_data;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_read_data,
        output gnt0, rvalid0, gnt1, rvalid1, rdata,
        output mem_address, mem_write_data, mem_memwrite, mem_memread
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_read_data,
        input  gnt0, rvalid0, gnt1, rvalid1, rdata,
        input  mem_address, mem_write_data, mem_memwrite, mem_memread
    );
endinterface

// File: rtl/d_mem_arbiter.sv
// Round-robin two-port arbiter/sequencer in front of single-ported D_MEM, one transaction in flight.
// Latency: gnt 1 cycle after the sampling edge, rvalid READ_LAT+2 cycles after it; write lands with gnt.
// Backpressure: requests are only sampled in IDLE; losers and late arrivals simply keep req held.
// Ports: clk, reset (async, active low), bus (d_mem_arbiter_if.slave) carrying
//        both requester ports, shared rdata and the D_MEM address/data/strobe bus.
module d_mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic           clk,
    input  logic           reset,
    d_mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic              lat_we;
    logic              lat_port;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] rdata_q;
    logic [2:0]        wait_cnt;

    // Port granted most recently. Resets to 1 so the first contest goes to port 0.
    logic              last_port;

    logic              any_req;
    logic              pick;

    // Winner selection, only consumed in IDLE.
    always_comb begin
        any_req = bus.req0 | bus.req1;
        pick    = 1'b0;
        if (bus.req0 && bus.req1) begin
            pick = ~last_port;
        end else begin
            pick = bus.req1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_we    <= 1'b0;
            lat_port  <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            last_port <= 1'b1;
            wait_cnt  <= 3'd0;
            rdata_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        lat_we    <= pick ? bus.we1    : bus.we0;
                        lat_addr  <= pick ? bus.addr1  : bus.addr0;
                        lat_wdata <= pick ? bus.wdata1 : bus.wdata0;
                        lat_port  <= pick;
                        // The grant is unconditional once latched, so the
                        // pointer can move here rather than in ISSUE.
                        last_port <= pick;
                    end
                end
                ISSUE: begin
                    if (!lat_we) begin
                        wait_cnt <= 3'(READ_LAT);
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 3'd1;
                    if (wait_cnt == 3'd1) begin
                        rdata_q <= bus.mem_read_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next state and outputs. Strobes, grants and valids are pure decodes of
    // the state plus latched owner, so an async reset clears them at once.
    always_comb begin
        state_nxt          = state;
        bus.gnt0           = 1'b0;
        bus.gnt1           = 1'b0;
        bus.rvalid0        = 1'b0;
        bus.rvalid1        = 1'b0;
        bus.mem_memwrite   = 1'b0;
        bus.mem_memread    = 1'b0;
        bus.rdata          = rdata_q;
        bus.mem_address    = lat_addr;
        bus.mem_write_data = lat_wdata;

        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                bus.gnt0         = ~lat_port;
                bus.gnt1         = lat_port;
                bus.mem_memwrite = lat_we;
                bus.mem_memread  = ~lat_we;
                state_nxt        = lat_we ? IDLE : WAIT;
            end
            WAIT: begin
                if (wait_cnt == 3'd1) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                bus.rvalid0 = ~lat_port;
                bus.rvalid1 = lat_port;
                state_nxt   = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_d_mem_arbiter.sv
// Directed bench for d_mem_arbiter: instance a uses READ_LAT=1, instance b READ_LAT=3.
// Each instance sits in front of its own behavioural single-ported memory.
// Inputs change and outputs are checked just after the falling edge.
module tb_d_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    d_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifa ();
    d_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifb ();

    d_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(1)) dut_a (
        .clk   (clk),
        .reset (rst_n),
        .bus   (ifa)
    );

    d_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(3)) dut_b (
        .clk   (clk),
        .reset (rst_n),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: registered read, then a delay line so data is presented
    // only in the last cycle of the read latency; poison value otherwise.
    logic [DW-1:0] mem_a [0:255];
    logic [DW-1:0] mem_b [0:255];
    logic [DW-1:0] pipe_a;
    logic [DW-1:0] pipe_b [0:2];

    always @(posedge clk) begin
        if (ifa.mem_memwrite) mem_a[ifa.mem_address[7:0]] <= ifa.mem_write_data;
        pipe_a <= ifa.mem_memread ? mem_a[ifa.mem_address[7:0]] : 32'hDEADBEEF;
        if (ifb.mem_memwrite) mem_b[ifb.mem_address[7:0]] <= ifb.mem_write_data;
        pipe_b[0] <= ifb.mem_memread ? mem_b[ifb.mem_address[7:0]] : 32'hDEADBEEF;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end

    assign ifa.mem_read_data = pipe_a;
    assign ifb.mem_read_data = pipe_b[2];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        ifa.req0 = 0; ifa.we0 = 0; ifa.addr0 = '0; ifa.wdata0 = '0;
        ifa.req1 = 0; ifa.we1 = 0; ifa.addr1 = '0; ifa.wdata1 = '0;
        ifb.req0 = 0; ifb.we0 = 0; ifb.addr0 = '0; ifb.wdata0 = '0;
        ifb.req1 = 0; ifb.we1 = 0; ifb.addr1 = '0; ifb.wdata1 = '0;
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end

        // Reset state
        repeat (2) tick();
        check("rst_gnt0", ifa.gnt0, 0);
        check("rst_gnt1", ifa.gnt1, 0);
        check("rst_rvalid0", ifa.rvalid0, 0);
        check("rst_rdata", ifa.rdata, 0);
        check("rst_memwrite", ifa.mem_memwrite, 0);
        check("rst_memread", ifa.mem_memread, 0);
        check("rst_addr", ifa.mem_address, 0);
        rst_n = 1'b1;

        // Port 0 write 0x1100 to 0xA
        tick();
        ifa.req0 = 1; ifa.we0 = 1; ifa.addr0 = 32'hA; ifa.wdata0 = 32'h1100;
        tick();
        check("wr_gnt0", ifa.gnt0, 1);
        check("wr_gnt1", ifa.gnt1, 0);
        check("wr_memwrite", ifa.mem_memwrite, 1);
        check("wr_memread", ifa.mem_memread, 0);
        check("wr_addr", ifa.mem_address, 32'hA);
        check("wr_wdata", ifa.mem_write_data, 32'h1100);
        ifa.req0 = 0;
        tick();
        check("wr_gnt0_drop", ifa.gnt0, 0);
        check("wr_memwrite_drop", ifa.mem_memwrite, 0);
        check("wr_addr_hold", ifa.mem_address, 32'hA);

        // Port 0 read-back of 0xA, READ_LAT=1: rvalid 3 cycles after the request edge
        ifa.req0 = 1; ifa.we0 = 0; ifa.addr0 = 32'hA;
        tick();
        check("rd_gnt0", ifa.gnt0, 1);
        check("rd_memread", ifa.mem_memread, 1);
        check("rd_memwrite", ifa.mem_memwrite, 0);
        ifa.req0 = 0;
        tick();
        check("rd_memread_wait", ifa.mem_memread, 0);
        check("rd_rvalid0_early", ifa.rvalid0, 0);
        tick();
        check("rd_rvalid0", ifa.rvalid0, 1);
        check("rd_rdata", ifa.rdata, 32'h1100);
        check("rd_rvalid1", ifa.rvalid1, 0);
        tick();
        check("rd_rvalid0_drop", ifa.rvalid0, 0);
        check("rd_rdata_hold", ifa.rdata, 32'h1100);

        // Both ports write continuously after a fresh reset: 0,1,0,1 every 2 cycles
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        ifa.req0 = 1; ifa.we0 = 1; ifa.addr0 = 32'hA; ifa.wdata0 = 32'h2200;
        ifa.req1 = 1; ifa.we1 = 1; ifa.addr1 = 32'hB; ifa.wdata1 = 32'h1111;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("rr_gnt0_%0d", i), ifa.gnt0, (i % 4 == 0));
            check($sformatf("rr_gnt1_%0d", i), ifa.gnt1, (i % 4 == 2));
            check($sformatf("rr_memwrite_%0d", i), ifa.mem_memwrite, (i % 2 == 0));
            check($sformatf("rr_addr_%0d", i), ifa.mem_address, (i % 4 < 2) ? 32'hA : 32'hB);
        end
        ifa.req0 = 0;
        ifa.req1 = 0;

        // Port 1 read of 0xB
        tick();
        ifa.req1 = 1; ifa.we1 = 0; ifa.addr1 = 32'hB;
        tick();
        check("p1rd_gnt1", ifa.gnt1, 1);
        check("p1rd_gnt0", ifa.gnt0, 0);
        check("p1rd_memread", ifa.mem_memread, 1);
        ifa.req1 = 0;
        tick();
        tick();
        check("p1rd_rvalid1", ifa.rvalid1, 1);
        check("p1rd_rdata", ifa.rdata, 32'h1111);
        check("p1rd_rvalid0", ifa.rvalid0, 0);

        // Instance b (READ_LAT=3): seed 0x5, then read it while port 1 waits
        ifb.req0 = 1; ifb.we0 = 1; ifb.addr0 = 32'h5; ifb.wdata0 = 32'hCAFE;
        tick();
        check("b_wr_gnt0", ifb.gnt0, 1);
        check("b_wr_memwrite", ifb.mem_memwrite, 1);
        ifb.req0 = 0;
        tick();
        ifb.req0 = 1; ifb.we0 = 0; ifb.addr0 = 32'h5;
        tick();
        check("b_rd_gnt0", ifb.gnt0, 1);
        check("b_rd_memread", ifb.mem_memread, 1);
        ifb.req0 = 0;
        ifb.req1 = 1; ifb.we1 = 1; ifb.addr1 = 32'h6; ifb.wdata1 = 32'h66;
        for (int c = 2; c <= 6; c++) begin
            tick();
            check($sformatf("b_gnt1_blocked_%0d", c), ifb.gnt1, 0);
            check($sformatf("b_rvalid0_%0d", c), ifb.rvalid0, (c == 5));
            if (c == 5) check("b_rdata", ifb.rdata, 32'hCAFE);
        end
        tick();
        check("b_gnt1", ifb.gnt1, 1);
        check("b_gnt1_memwrite", ifb.mem_memwrite, 1);
        check("b_gnt1_addr", ifb.mem_address, 32'h6);
        check("b_gnt1_wdata", ifb.mem_write_data, 32'h66);
        ifb.req1 = 0;

        // Reset during WAIT of a read
        tick();
        ifb.req0 = 1; ifb.we0 = 0; ifb.addr0 = 32'h5;
        tick();
        check("b_rst_rd_gnt0", ifb.gnt0, 1);
        ifb.req0 = 0;
        tick();
        rst_n = 1'b0;
        #1;
        check("async_rst_rdata", ifb.rdata, 0);
        check("async_rst_addr", ifb.mem_address, 0);
        check("async_rst_wdata", ifb.mem_write_data, 0);
        check("async_rst_memread", ifb.mem_memread, 0);
        check("async_rst_memwrite", ifb.mem_memwrite, 0);
        check("async_rst_gnt0", ifb.gnt0, 0);
        check("async_rst_rvalid0", ifb.rvalid0, 0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            check($sformatf("post_rst_rvalid0_%0d", c), ifb.rvalid0, 0);
            check($sformatf("post_rst_rvalid1_%0d", c), ifb.rvalid1, 0);
        end
        ifb.req0 = 1; ifb.we0 = 1; ifb.addr0 = 32'h7; ifb.wdata0 = 32'h77;
        ifb.req1 = 1; ifb.we1 = 1; ifb.addr1 = 32'h8; ifb.wdata1 = 32'h88;
        tick();
        check("post_rst_gnt0", ifb.gnt0, 1);
        check("post_rst_gnt1", ifb.gnt1, 0);
        check("post_rst_addr", ifb.mem_address, 32'h7);
        ifb.req0 = 0;
        ifb.req1 = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
